// File: rtl/uart_pkg.sv
// Shared encodings for the parameterised UART transmitter: FSM state codes,
// parity-mode constants and the per-frame configuration captured at frame start.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef struct packed {
        logic [1:0] parity_mode;
        logic       stop2;
    } frame_cfg_t;

    // Encoding 2'b11 is reserved and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side bundle of the UART transmitter: baud tick, write port, frame
// options, serial line and FIFO status.
interface uart_tx_param_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          clken;
    logic [DATA_W-1:0]             din;
    logic                          wr_en;
    logic [1:0]                    parity_mode;
    logic                          stop2;
    logic                          tx;
    logic                          tx_busy;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output clken, din, wr_en, parity_mode, stop2,
        input  tx, tx_busy, full, fifo_count, overflow
    );

    modport slave (
        input  clken, din, wr_en, parity_mode, stop2,
        output tx, tx_busy, full, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with a fall-through read port; a push into a full FIFO is
// dropped and reported by a one-cycle overflow pulse.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk_50m,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Fullness is judged before this cycle's pop, so a push into a full FIFO
    // is dropped even when the same edge frees a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push && full;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, regardless of block order.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk_50m) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-fed frame FSM with optional parity and
// one or two stop bits, one serial bit per clken period, registered tx.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk_50m,
    input  logic           rst,
    uart_tx_param_if.slave bus
);
    localparam int BIT_CNT_W = $clog2(DATA_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    logic [2:0]           state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    frame_cfg_t           cfg_q, cfg_d;
    logic                 tx_q, tx_d;

    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [DATA_W-1:0]    fifo_dout;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .push     (bus.wr_en),
        .pop      (fifo_pop),
        .din      (bus.din),
        .dout     (fifo_dout),
        .full     (bus.full),
        .empty    (fifo_empty),
        .count    (bus.fifo_count),
        .overflow (bus.overflow)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        cfg_d     = cfg_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            // Frame options are captured with the word, so mid-frame changes
            // only apply from the next frame onward.
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop          = 1'b1;
                    data_d            = fifo_dout;
                    cfg_d.parity_mode = bus.parity_mode;
                    cfg_d.stop2       = bus.stop2;
                    state_d           = START;
                end
            end
            START: begin
                if (bus.clken) begin
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bus.clken) begin
                    tx_d = data_q[bit_cnt_q];
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = parity_enabled(cfg_q.parity_mode) ? PARITY : STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bus.clken) begin
                    tx_d    = (^data_q) ^ (cfg_q.parity_mode == PAR_ODD);
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (bus.clken) begin
                    tx_d    = 1'b1;
                    state_d = cfg_q.stop2 ? STOP2 : IDLE;
                end
            end
            STOP2: begin
                if (bus.clken) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_cnt_q <= '0;
            cfg_q     <= '{parity_mode: PAR_NONE, stop2: 1'b0};
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            cfg_q     <= cfg_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = (state_q != IDLE) || (bus.fifo_count != '0);

endmodule
